// File: rtl/mux_pkg.sv
// Shared constants for the stream multiplexer slice: mode encodings and
// default sizing used by the top level and its bench.
package mux_pkg;

    localparam logic MODE_FIXED    = 1'b0;
    localparam logic MODE_RR       = 1'b1;

    localparam int   DEFAULT_WIDTH = 8;
    localparam int   DEFAULT_NCH   = 4;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: returns the lowest requesting index at or above
// ptr, otherwise wraps to the lowest requesting index overall.
module rr_pick #(
    parameter int NCH   = 4,
    parameter int SEL_W = 2
) (
    input  logic [NCH-1:0]   req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant,
    output logic             found
);

    logic             hi_found;
    logic             lo_found;
    logic [SEL_W-1:0] hi_idx;
    logic [SEL_W-1:0] lo_idx;

    // Scan downward so the last hit is the lowest index in each half-range.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = SEL_W'(i);
                if (SEL_W'(i) >= ptr) begin
                    hi_found = 1'b1;
                    hi_idx   = SEL_W'(i);
                end
            end
        end
        found = lo_found;
        grant = hi_found ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel stream multiplexer with a single output register. Channels are
// chosen either by a fixed select or by round-robin arbitration.
module stream_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int NCH   = DEFAULT_NCH,
    parameter int SEL_W = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     sel,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH*WIDTH-1:0] in_data,
    output logic [NCH-1:0]       in_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SEL_W-1:0]     out_ch
);

    logic [NCH-1:0]   req;
    logic [WIDTH-1:0] words [NCH];
    logic [SEL_W-1:0] grant;
    logic             found;
    logic             load;
    logic [WIDTH-1:0] grant_word;
    logic [SEL_W-1:0] ptr_next;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [SEL_W-1:0] out_ch_reg;
    logic [SEL_W-1:0] ptr_reg;

    // Eligibility per channel; a select beyond NCH-1 matches no channel.
    generate
        for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
            assign req[gi]   = in_valid[gi] & ((mode == MODE_RR) | (sel == SEL_W'(gi)));
            assign words[gi] = in_data[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // In fixed mode at most one request is set, so the picker simply finds it.
    rr_pick #(
        .NCH   (NCH),
        .SEL_W (SEL_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .grant (grant),
        .found (found)
    );

    // Load when the output register is free or draining and someone is granted.
    assign load     = rst_n & found & (~out_valid_reg | out_ready);
    assign ptr_next = (grant == SEL_W'(NCH - 1)) ? '0 : grant + 1'b1;

    // Word mux and one-hot handshake on the granted channel.
    always_comb begin
        grant_word = '0;
        in_ready   = '0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == SEL_W'(i)) begin
                grant_word  = words[i];
                in_ready[i] = load;
            end
        end
    end

    // Output register and round-robin pointer.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_ch_reg    <= '0;
            ptr_reg       <= '0;
        end else if (load) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= grant_word;
            out_ch_reg    <= grant;
            if (mode == MODE_RR) begin
                ptr_reg <= ptr_next;
            end
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_ch    = out_ch_reg;

endmodule
